var_state_bank: RTL

- Per-variable assignment store that sits directly upstream of the clause cells.
- Drives each clause cell's var_value_i and var_lvl_i.
- Absorbs the merged var_value_o implications coming back from the clause array.
- Executes decisions from the search controller and performs level-based backtrack by a sequential per-variable sweep.
- Detects assignment conflicts and reports the conflicting variable and level.

---
 rtl/var_state_bank.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/var_state_bank.sv
// rtl/var_state_bank.sv - per-variable assignment store with decision, implication and backtrack sweep
module var_state_bank #(
  parameter int NUM_VARS   = 8,
  parameter int WIDTH_LVL  = 16,
  parameter int WIDTH_VIDX = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          upd_valid_i,
  input  logic [NUM_VARS*3-1:0]         upd_value_i,
  input  logic                          dec_valid_i,
  input  logic [WIDTH_VIDX-1:0]         dec_var_i,
  input  logic [1:0]                    dec_value_i,
  input  logic                          bkt_valid_i,
  input  logic [WIDTH_LVL-1:0]          bkt_lvl_i,
  output logic [NUM_VARS*3-1:0]         var_value_o,
  output logic [NUM_VARS*WIDTH_LVL-1:0] var_lvl_o,
  output logic [WIDTH_LVL-1:0]          cur_lvl_o,
  output logic                          busy_o,
  output logic                          bkt_done_o,
  output logic                          conflict_o,
  output logic [WIDTH_VIDX-1:0]         conflict_var_o,
  output logic [WIDTH_LVL-1:0]          conflict_lvl_o,
  output logic                          dec_err_o,
  output logic                          all_assigned_o
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                state, state_nxt;
  logic [2:0]            val [NUM_VARS];
  logic [WIDTH_LVL-1:0]  lvl [NUM_VARS];
  logic [WIDTH_LVL-1:0]  cur_lvl;
  logic [WIDTH_LVL-1:0]  target;
  logic [WIDTH_VIDX-1:0] idx;
  logic                  conflict;
  logic [WIDTH_VIDX-1:0] conflict_var;
  logic [WIDTH_LVL-1:0]  conflict_lvl;
  logic                  dec_err;

  logic [NUM_VARS-1:0]   upd_store;
  logic [NUM_VARS-1:0]   upd_conf_vec;
  logic                  upd_conf;
  logic [WIDTH_VIDX-1:0] upd_cvar;
  logic                  dec_in_range;
  logic                  dec_free;
  logic                  dec_ok;

  always_comb begin
    upd_store    = '0;
    upd_conf_vec = '0;
    upd_conf     = 1'b0;
    upd_cvar     = '0;
    for (int i = 0; i < NUM_VARS; i++) begin
      upd_conf_vec[i] = (upd_value_i[3*i +: 2] == 2'b11) ||
                        ((upd_value_i[3*i +: 2] != 2'b00) && (val[i][1:0] != 2'b00) &&
                         (upd_value_i[3*i +: 2] != val[i][1:0]));
      upd_store[i]    = (val[i][1:0] == 2'b00) && (upd_value_i[3*i +: 2] != 2'b00) &&
                        (upd_value_i[3*i +: 2] != 2'b11);
    end
    // Scan downward so the lowest conflicting index is the one left standing.
    for (int i = NUM_VARS - 1; i >= 0; i--) begin
      if (upd_conf_vec[i]) begin
        upd_conf = 1'b1;
        upd_cvar = WIDTH_VIDX'(i);
      end
    end
  end

  always_comb begin
    dec_in_range = 1'b0;
    dec_free     = 1'b0;
    for (int i = 0; i < NUM_VARS; i++) begin
      if (int'(dec_var_i) == i) begin
        dec_in_range = 1'b1;
        dec_free     = (val[i][1:0] == 2'b00);
      end
    end
    dec_ok = dec_in_range && dec_free && (dec_value_i == 2'b01 || dec_value_i == 2'b10) &&
             (cur_lvl != '1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bkt_valid_i) state_nxt = SCAN;
      SCAN:    if (int'(idx) == NUM_VARS - 1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_VARS; i++) begin
        val[i] <= 3'b000;
        lvl[i] <= '0;
      end
      cur_lvl      <= '0;
      target       <= '0;
      idx          <= '0;
      conflict     <= 1'b0;
      conflict_var <= '0;
      conflict_lvl <= '0;
      dec_err      <= 1'b0;
    end else begin
      dec_err <= 1'b0;
      case (state)
        IDLE: begin
          if (bkt_valid_i) begin
            target <= bkt_lvl_i;
            idx    <= '0;
          end else if (!conflict && dec_valid_i) begin
            if (dec_ok) begin
              cur_lvl <= cur_lvl + 1'b1;
              for (int i = 0; i < NUM_VARS; i++) begin
                if (int'(dec_var_i) == i) begin
                  val[i] <= {1'b0, dec_value_i};
                  lvl[i] <= cur_lvl + 1'b1;
                end
              end
            end else begin
              dec_err <= 1'b1;
            end
          end else if (!conflict && upd_valid_i) begin
            if (upd_conf) begin
              conflict     <= 1'b1;
              conflict_var <= upd_cvar;
              conflict_lvl <= cur_lvl;
            end else begin
              for (int i = 0; i < NUM_VARS; i++) begin
                if (upd_store[i]) begin
                  val[i] <= upd_value_i[3*i +: 3];
                  lvl[i] <= cur_lvl;
                end
              end
            end
          end
        end
        SCAN: begin
          for (int i = 0; i < NUM_VARS; i++) begin
            if (int'(idx) == i && lvl[i] > target) begin
              val[i] <= 3'b000;
              lvl[i] <= '0;
            end
          end
          idx <= idx + 1'b1;
        end
        DONE: begin
          if (target < cur_lvl) cur_lvl <= target;
          conflict     <= 1'b0;
          conflict_var <= '0;
          conflict_lvl <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    var_value_o    = '0;
    var_lvl_o      = '0;
    all_assigned_o = 1'b1;
    for (int i = 0; i < NUM_VARS; i++) begin
      var_value_o[3*i +: 3]                = val[i];
      var_lvl_o[WIDTH_LVL*i +: WIDTH_LVL]  = lvl[i];
      if (val[i][1:0] == 2'b00) all_assigned_o = 1'b0;
    end
  end

  assign cur_lvl_o      = cur_lvl;
  assign busy_o         = (state != IDLE);
  assign bkt_done_o     = (state == DONE);
  assign conflict_o     = conflict;
  assign conflict_var_o = conflict_var;
  assign conflict_lvl_o = conflict_lvl;
  assign dec_err_o      = dec_err;

endmodule
